mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, giving the memory depth in 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, giving the extra wait states before the response; legal range 0..15.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0; it SHALL be word-aligned.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port mem_valid_i, input, 1 bit: initiator request valid.
REQ-007 SHALL have port mem_ready_o, output, 1 bit: a one-cycle completion pulse.
REQ-008 SHALL have port mem_addr_i, input, RISCV_ADDR_WIDTH bits: byte address.
REQ-009 SHALL have port mem_wdata_i, input, RISCV_WORD_WIDTH bits: write data, lane-aligned.
REQ-010 SHALL have port mem_we_i, input, 4 bits: byte write enables; 4'b0000 means read.
REQ-011 SHALL have port mem_rdata_o, output, RISCV_WORD_WIDTH bits: read data, valid only while mem_ready_o=1.
REQ-012 SHALL have port err_o, output, 1 bit: sticky out-of-range flag.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-014 IDLE: when mem_valid_i=1, SHALL go to WAIT with the counter loaded to WAIT_CYCLES-1, or to RESP directly if WAIT_CYCLES=0.
REQ-015 WAIT: SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0 and mem_valid_i=1.
REQ-016 On the edge entering RESP, SHALL latch the read word into mem_rdata_o and commit the write to the enabled byte lanes only.
REQ-017 RESP: SHALL drive mem_ready_o=1 for exactly one cycle, then always return to IDLE; a request held high is treated as new from the following IDLE cycle.
REQ-018 Latency from the first cycle with mem_valid_i=1 to mem_ready_o=1 SHALL be WAIT_CYCLES+1 cycles; throughput is one transaction per WAIT_CYCLES+2 cycles.
REQ-019 SHALL ignore mem_addr_i[1:0]; the word index is (mem_addr_i-BASE_ADDR)>>2.
REQ-020 The initiator SHALL hold addr, wdata and we stable from mem_valid_i rise until mem_ready_o; the responder samples them only on the RESP-entry edge.
REQ-021 mem_valid_i falling in WAIT SHALL abort to IDLE: no write, no ready pulse, rdata unchanged.
REQ-022 An address below BASE_ADDR or with word index >= MEM_WORDS SHALL still complete with normal latency, with the write dropped, rdata=0 and err_o set.
REQ-023 A read with mem_we_i=0 and a write SHALL never both occur; any nonzero mem_we_i is a write and returns the pre-write word on mem_rdata_o.
REQ-024 mem_rdata_o SHALL read 0 in every cycle where mem_ready_o=0.

Reset
REQ-025 rst_n low SHALL immediately force state to IDLE, mem_ready_o=0, mem_rdata_o=0, err_o=0 and counter=0, including in mid-transaction.
REQ-026 Memory array contents SHALL NOT be reset and SHALL retain their values across reset.
REQ-027 err_o SHALL clear only by reset.

Structure
REQ-028 RISCV_ADDR_WIDTH and RISCV_WORD_WIDTH SHALL come from the shared riscv_defines package; the FSM state enum SHALL live in that package.
REQ-029 SHALL instantiate one sub-module, mem_array: a synchronous single-port RAM with 4-lane byte write enables.

Verification
REQ-030 WAIT_CYCLES=1: write 32'hDEADBEEF to 0x10 with we=4'hF, then read 0x10 -> each ready arrives 2 cycles after valid; read returns 32'hDEADBEEF.
REQ-031 Byte lanes: with 0x20=32'h11223344, write 32'hAABBCCDD with we=4'b0101 -> read returns 32'h11BB33DD.
REQ-032 Abort: valid high 1 cycle with WAIT_CYCLES=3, write 0x30, then drop -> no ready; 0x30 unchanged.
REQ-033 Out of range, MEM_WORDS=1024: read 0x1000 -> ready after WAIT_CYCLES+1 cycles, rdata=0, err_o=1 and stays 1.
REQ-034 Reset in WAIT: rst_n low mid-transaction -> ready, rdata and err_o are 0; the next request completes with full latency.
REQ-035 WAIT_CYCLES=0, valid held high for 4 requests -> ready on cycles 1, 3, 5 and 7.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared RISC-V bus widths and the memory responder's FSM state encoding.
package riscv_defines;

   localparam int RISCV_ADDR_WIDTH = 32;
   localparam int RISCV_WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port word RAM with four byte-lane write enables.
// Read-first: a write cycle returns the word as it was before the write.
module mem_array
   import riscv_defines::*;
#(
   parameter int WORDS = 1024,
   parameter int AW    = 10
) (
   input  logic                        clk,
   input  logic                        en_i,
   input  logic [AW-1:0]               addr_i,
   input  logic [3:0]                  we_i,
   input  logic [RISCV_WORD_WIDTH-1:0] wdata_i,
   output logic [RISCV_WORD_WIDTH-1:0] rdata_o
);

   logic [RISCV_WORD_WIDTH-1:0] mem_q [WORDS];
   logic [RISCV_WORD_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i) begin
         rdata_q <= mem_q[addr_i];
         for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
               mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-bus responder: valid/ready handshake with programmable wait states
// in front of a byte-writable RAM, plus a sticky out-of-range error flag.
module mem_responder
   import riscv_defines::*;
#(
   parameter int                          MEM_WORDS   = 1024,
   parameter int                          WAIT_CYCLES = 1,
   parameter logic [RISCV_ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        mem_valid_i,
   output logic                        mem_ready_o,
   input  logic [RISCV_ADDR_WIDTH-1:0] mem_addr_i,
   input  logic [RISCV_WORD_WIDTH-1:0] mem_wdata_i,
   input  logic [3:0]                  mem_we_i,
   output logic [RISCV_WORD_WIDTH-1:0] mem_rdata_o,
   output logic                        err_o
);

   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   mem_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   logic       oor_q, oor_d;
   logic       enter_resp;

   logic [RISCV_ADDR_WIDTH-1:0] offset;
   logic [RISCV_ADDR_WIDTH-1:0] word_idx;
   logic                        in_range;
   logic [1:0]                  unused_byte_offset;
   logic [RISCV_WORD_WIDTH-1:0] ram_rdata;

   // Byte-offset bits are irrelevant: the RAM is word-addressed.
   assign offset             = mem_addr_i - BASE_ADDR;
   assign word_idx           = {2'b00, offset[RISCV_ADDR_WIDTH-1:2]};
   assign unused_byte_offset = offset[1:0];
   assign in_range           = (mem_addr_i >= BASE_ADDR) && (word_idx < $unsigned(MEM_WORDS));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      oor_d      = oor_q;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_valid_i) begin
               if (WAIT_CYCLES == 0) begin
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         WAIT: begin
            if (!mem_valid_i) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd0) begin
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Request attributes are sampled only on the edge that enters RESP.
      if (enter_resp) begin
         state_d = RESP;
         oor_d   = !in_range;
         if (!in_range) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
         oor_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         oor_q   <= oor_d;
      end
   end

   mem_array #(
      .WORDS (MEM_WORDS),
      .AW    (AW)
   ) u_mem_array (
      .clk     (clk),
      .en_i    (enter_resp && in_range),
      .addr_i  (offset[AW+1:2]),
      .we_i    (mem_we_i),
      .wdata_i (mem_wdata_i),
      .rdata_o (ram_rdata)
   );

   assign mem_ready_o = (state_q == RESP);
   assign mem_rdata_o = (mem_ready_o && !oor_q) ? ram_rdata : '0;
   assign err_o       = err_q;

endmodule
